// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one data-memory slave port between
// the fetch master (0) and the memory-stage master (1).
module mem_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              ma_clk,
  input  logic              ma_rst,
  input  logic              ma_i_cyc0,
  input  logic              ma_i_cyc1,
  input  logic              ma_i_stb0,
  input  logic              ma_i_stb1,
  input  logic              ma_i_we0,
  input  logic              ma_i_we1,
  input  logic [3:0]        ma_i_be0,
  input  logic [3:0]        ma_i_be1,
  input  logic [AWIDTH-1:0] ma_i_addr0,
  input  logic [AWIDTH-1:0] ma_i_addr1,
  input  logic [DWIDTH-1:0] ma_i_wdata0,
  input  logic [DWIDTH-1:0] ma_i_wdata1,
  output logic [DWIDTH-1:0] ma_o_rdata0,
  output logic [DWIDTH-1:0] ma_o_rdata1,
  output logic              ma_o_ack0,
  output logic              ma_o_ack1,
  output logic              ma_o_err0,
  output logic              ma_o_err1,
  output logic              ma_o_stall0,
  output logic              ma_o_stall1,
  output logic              ma_o_cyc,
  output logic              ma_o_stb,
  output logic              ma_o_we,
  output logic [3:0]        ma_o_be,
  output logic [AWIDTH-1:0] ma_o_load_addr,
  output logic [AWIDTH-1:0] ma_o_store_addr,
  output logic [DWIDTH-1:0] ma_o_store_data,
  input  logic [DWIDTH-1:0] ma_i_load_data,
  input  logic              ma_i_ack,
  input  logic              ma_i_stall,
  output logic [1:0]        ma_o_grant
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t            r_state;
  logic              r_last, r_err0, r_err1;
  logic [CW-1:0]     r_cnt;
  logic              w_req0, w_req1, w_own0, w_own1, w_busy;
  logic              w_mcyc, w_mstb, w_mwe, w_tout, w_done, w_terr;
  logic [3:0]        w_mbe;
  logic [AWIDTH-1:0] w_maddr;
  logic [DWIDTH-1:0] w_mwdata;
  assign w_req0   = ma_i_cyc0 & ma_i_stb0;
  assign w_req1   = ma_i_cyc1 & ma_i_stb1;
  assign w_own0   = r_state == BUSY0;
  assign w_own1   = r_state == BUSY1;
  assign w_busy   = w_own0 | w_own1;
  assign w_mcyc   = w_own1 ? ma_i_cyc1   : ma_i_cyc0;
  assign w_mstb   = w_own1 ? ma_i_stb1   : ma_i_stb0;
  assign w_mwe    = w_own1 ? ma_i_we1    : ma_i_we0;
  assign w_mbe    = w_own1 ? ma_i_be1    : ma_i_be0;
  assign w_maddr  = w_own1 ? ma_i_addr1  : ma_i_addr0;
  assign w_mwdata = w_own1 ? ma_i_wdata1 : ma_i_wdata0;
  assign w_tout   = (TIMEOUT != 0) && (r_cnt == TLIM);
  // ack beats abort beats timeout; only an un-acked, un-aborted expiry errors
  assign w_done   = ma_i_ack | ~w_mcyc | w_tout;
  assign w_terr   = ~ma_i_ack & w_mcyc & w_tout;
  assign ma_o_cyc        = w_busy & w_mcyc;
  assign ma_o_stb        = w_busy & w_mcyc & w_mstb;
  assign ma_o_we         = w_busy & w_mwe;
  assign ma_o_be         = w_busy ? w_mbe : '0;
  assign ma_o_load_addr  = (w_busy & ~w_mwe) ? w_maddr : '0;
  assign ma_o_store_addr = (w_busy & w_mwe) ? w_maddr : '0;
  assign ma_o_store_data = w_busy ? w_mwdata : '0;
  assign ma_o_rdata0     = ma_i_load_data;
  assign ma_o_rdata1     = ma_i_load_data;
  assign ma_o_ack0       = w_own0 & ma_i_ack;
  assign ma_o_ack1       = w_own1 & ma_i_ack;
  assign ma_o_stall0     = w_own0 ? (ma_i_stall & ~ma_i_ack) : w_req0;
  assign ma_o_stall1     = w_own1 ? (ma_i_stall & ~ma_i_ack) : w_req1;
  assign ma_o_err0       = r_err0;
  assign ma_o_err1       = r_err1;
  assign ma_o_grant      = {w_own1, w_own0};
  always_ff @(posedge ma_clk or negedge ma_rst)
    if (!ma_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      r_err0 <= w_own0 & w_terr;
      r_err1 <= w_own1 & w_terr;
      if (!w_busy) begin
        r_cnt <= '0;
        if (w_req0 && (!w_req1 || r_last)) r_state <= BUSY0;
        else if (w_req1) r_state <= BUSY1;
      end else if (w_done) begin
        r_state <= IDLE;
        r_last  <= w_own1;
        r_cnt   <= '0;
      end else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
endmodule
